// File: rtl/button_events.sv
// Decodes a debounced button level into press/release/click/long/double-click pulses.
// Optional auto-repeat in the long-press state is built only when BUTTON_REPEAT_EN is defined.
module button_events #(
  parameter logic PRESSED_LEVEL = 1'b0,
  parameter int   LONG_DELAY    = 20,
  parameter int   DOUBLE_DELAY  = 18,
  parameter int   REPEAT_DELAY  = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       signal,
  output logic       held,
  output logic       press,
  // "release" is a reserved word in SystemVerilog, so the release pulse carries a suffix.
  output logic       release_event,
  output logic       click,
  output logic       long_press,
  output logic       double_click,
  output logic       repeat_tick,
  output logic [2:0] debug_state
);

  localparam int CW_LD = (LONG_DELAY > DOUBLE_DELAY) ? LONG_DELAY : DOUBLE_DELAY;
  localparam int CW    = (CW_LD > REPEAT_DELAY) ? CW_LD : REPEAT_DELAY;

  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LONG_TERM   = {CW{1'b1}} >> (CW - LONG_DELAY);
  localparam logic [CW-1:0] DOUBLE_TERM = {CW{1'b1}} >> (CW - DOUBLE_DELAY);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRESSED  = 3'd1;
  localparam logic [2:0] S_LONG     = 3'd2;
  localparam logic [2:0] S_WAIT2    = 3'd3;
  localparam logic [2:0] S_PRESSED2 = 3'd4;

  logic          pressed;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic press_nxt;
  logic release_nxt;
  logic click_nxt;
  logic long_nxt;
  logic double_nxt;

  assign pressed     = (signal == PRESSED_LEVEL);
  assign debug_state = state;

`ifdef BUTTON_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_TERM = {CW{1'b1}} >> (CW - REPEAT_DELAY);
  logic repeat_nxt;
  logic repeat_q;
  assign repeat_tick = repeat_q;
`else
  assign repeat_tick = 1'b0;
`endif

  // Release beats the long terminal and press beats the window terminal,
  // because the level checks come first in each state.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    click_nxt   = 1'b0;
    long_nxt    = 1'b0;
    double_nxt  = 1'b0;
`ifdef BUTTON_REPEAT_EN
    repeat_nxt  = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (pressed) begin
          state_nxt = S_PRESSED;
          press_nxt = 1'b1;
        end
      end

      S_PRESSED: begin
        if (!pressed) begin
          state_nxt   = S_WAIT2;
          release_nxt = 1'b1;
        end else if (cnt == LONG_TERM) begin
          state_nxt = S_LONG;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      S_LONG: begin
        if (!pressed) begin
          state_nxt   = S_IDLE;
          release_nxt = 1'b1;
        end else begin
`ifdef BUTTON_REPEAT_EN
          if (cnt == REPEAT_TERM) begin
            repeat_nxt = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end

      S_WAIT2: begin
        if (pressed) begin
          state_nxt = S_PRESSED2;
          press_nxt = 1'b1;
        end else if (cnt == DOUBLE_TERM) begin
          state_nxt = S_IDLE;
          click_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      S_PRESSED2: begin
        if (!pressed) begin
          state_nxt   = S_IDLE;
          release_nxt = 1'b1;
          double_nxt  = 1'b1;
        end else if (cnt == LONG_TERM) begin
          // The first press has become a lone click; the second one is now a long press.
          state_nxt = S_LONG;
          click_nxt = 1'b1;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      held          <= 1'b0;
      press         <= 1'b0;
      release_event <= 1'b0;
      click         <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      held          <= pressed;
      press         <= press_nxt;
      release_event <= release_nxt;
      click         <= click_nxt;
      long_press    <= long_nxt;
      double_click  <= double_nxt;
    end
  end

`ifdef BUTTON_REPEAT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_button_events.sv
// Randomized and directed stimulus for button_events, checked every cycle against an
// event-level reference model through an expected-value queue.
module tb_button_events;

  localparam int LONG_CYC = 16;
  localparam int WIN_CYC  = 8;
  localparam int REP_CYC  = 4;

  // Output vector bit positions.
  localparam int B_HELD = 6, B_PRESS = 5, B_REL = 4, B_CLICK = 3;
  localparam int B_LONG = 2, B_DBL = 1, B_TICK = 0;

  logic       clock;
  logic       reset;
  logic       signal;
  logic       held, press, release_event, click, long_press, double_click, repeat_tick;
  logic [2:0] debug_state;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];
  int         tot[7];
  int         snap[7];

  // Reference model: tracks the button in terms of presses, holds and release windows.
  bit m_prev, m_window, m_second, m_long;
  int m_run, m_rep;

  button_events #(
    .PRESSED_LEVEL(1'b0),
    .LONG_DELAY   (4),
    .DOUBLE_DELAY (3),
    .REPEAT_DELAY (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .signal       (signal),
    .held         (held),
    .press        (press),
    .release_event(release_event),
    .click        (click),
    .long_press   (long_press),
    .double_click (double_click),
    .repeat_tick  (repeat_tick),
    .debug_state  (debug_state)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  task automatic model_step();
    logic [6:0] e;
    bit p;
    e = '0;
    p = (signal == 1'b0);
    if (reset) begin
      m_prev = 0; m_window = 0; m_second = 0; m_long = 0; m_run = 0; m_rep = 0;
    end else begin
      e[B_HELD] = p;
      if (p && !m_prev) begin
        e[B_PRESS] = 1'b1;
        m_second   = m_window;
        m_window   = 0;
        m_long     = 0;
        m_run      = 0;
      end else if (!p && m_prev) begin
        e[B_REL] = 1'b1;
        m_run    = 0;
        if (!m_long) begin
          if (m_second) e[B_DBL] = 1'b1;
          else          m_window = 1;
        end
        m_second = 0;
      end else if (p) begin
        m_run++;
        if (!m_long && m_run == LONG_CYC) begin
          m_long     = 1;
          m_rep      = 0;
          e[B_LONG]  = 1'b1;
          e[B_CLICK] = m_second;
          m_second   = 0;
        end else if (m_long) begin
          m_rep++;
`ifdef BUTTON_REPEAT_EN
          if (m_rep == REP_CYC) begin
            e[B_TICK] = 1'b1;
            m_rep     = 0;
          end
`endif
        end
      end else if (m_window) begin
        m_run++;
        if (m_run == WIN_CYC) begin
          e[B_CLICK] = 1'b1;
          m_window   = 0;
        end
      end
      m_prev = p;
    end
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [6:0] act;
    logic [6:0] expv;
    for (int b = 0; b < 7; b++) tot[b] = 0;
    forever begin
      @(negedge clock);
      act = {held, press, release_event, click, long_press, double_click, repeat_tick};
      for (int b = 0; b < 7; b++) if (act[b] === 1'b1) tot[b]++;
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL outputs t=%0t actual=%b required=%b (held press release click long double tick)",
                   $time, act, expv);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit p, input int n);
    signal = p ? 1'b0 : 1'b1;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic mark();
    for (int b = 0; b < 7; b++) snap[b] = tot[b];
  endtask

  task automatic check_cnt(input string name, input string what, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s %s count actual=%0d required=%0d", name, what, actual, required);
    end
  endtask

  task automatic expect_counts(input string name, input int p, input int r, input int c,
                               input int l, input int d, input int t);
    check_cnt(name, "press",   tot[B_PRESS] - snap[B_PRESS], p);
    check_cnt(name, "release", tot[B_REL]   - snap[B_REL],   r);
    check_cnt(name, "click",   tot[B_CLICK] - snap[B_CLICK], c);
    check_cnt(name, "long",    tot[B_LONG]  - snap[B_LONG],  l);
    check_cnt(name, "double",  tot[B_DBL]   - snap[B_DBL],   d);
    check_cnt(name, "tick",    tot[B_TICK]  - snap[B_TICK],  t);
  endtask

  task automatic check_idle_state(input string name);
    checks++;
    if (debug_state !== 3'd0) begin
      errors++;
      $display("FAIL %s state actual=%0d required=0", name, debug_state);
    end
  endtask

  function automatic int pick_len();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(LONG_CYC - 1, LONG_CYC + 1);
      1:       return $urandom_range(WIN_CYC - 1, WIN_CYC + 1);
      default: return $urandom_range(1, 24);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit lvl;
    int ticks26;
`ifdef BUTTON_REPEAT_EN
    ticks26 = 2;
`else
    ticks26 = 0;
`endif
    reset  = 1'b1;
    signal = 1'b1;
    mark();
    do_reset(3);
    check_idle_state("reset_idle");
    drive(0, 20);
    expect_counts("idle", 0, 0, 0, 0, 0, 0);

    mark(); drive(1, 5); drive(0, 12);
    expect_counts("click", 1, 1, 1, 0, 0, 0);

    mark(); drive(1, 26); drive(0, 12);
    expect_counts("long", 1, 1, 0, 1, 0, ticks26);

    mark(); drive(1, 3); drive(0, 2); drive(1, 3); drive(0, 12);
    expect_counts("double", 2, 2, 0, 0, 1, 0);

    mark(); drive(1, LONG_CYC); drive(0, 12);
    expect_counts("release_at_long_edge", 1, 1, 1, 0, 0, 0);

    mark(); drive(1, 3); drive(0, WIN_CYC); drive(1, 3); drive(0, 12);
    expect_counts("press_at_window_edge", 2, 2, 0, 0, 1, 0);

    mark(); drive(1, 3); drive(0, WIN_CYC + 1); drive(1, 3); drive(0, 12);
    expect_counts("press_after_window", 2, 2, 2, 0, 0, 0);

    mark(); drive(1, 3); drive(0, 2); drive(1, 20); drive(0, 12);
    expect_counts("second_long", 2, 2, 1, 1, 0, 0);

    mark(); drive(1, 3); drive(0, 2); do_reset(2);
    check_idle_state("reset_wait2");
    drive(0, 15);
    expect_counts("reset_wait2", 1, 1, 0, 0, 0, 0);

    mark(); signal = 1'b0; do_reset(3); drive(1, 4); drive(0, 12);
    expect_counts("held_through_reset", 1, 1, 1, 0, 0, 0);

    lvl = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        lvl = !lvl;
        drive(lvl, pick_len());
      end
    end
    drive(0, 25);

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
